// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, requester id,
// access-size encoding and the misalignment rule.
package mem_arb_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 is also treated as a word

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DLOAD,
    DSTORE,
    DRMW_WR,
    RESP
  } state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_t;

  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    if (size == SZ_BYTE) return 1'b0;
    if (size == SZ_HALF) return lane[0];
    return lane != 2'b00;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: extracts/extends load data from a memory word and
// merges sub-word store data into a previously read word.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [DATA_W-1:0] rd_word,
  input  logic [1:0]        lane,
  input  logic [1:0]        size,
  input  logic              zero_ext,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output gets a default before the case/if tree so no path infers a latch.
    byte_sel   = rd_word[7:0];
    half_sel   = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_data  = rd_word;
    merge_data = wdata;

    case (lane)
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      2'd3:    byte_sel = rd_word[31:24];
      default: byte_sel = rd_word[7:0];
    endcase

    if (size == SZ_BYTE) begin
      load_data  = {{24{~zero_ext & byte_sel[7]}}, byte_sel};
      merge_data = rd_word;
      case (lane)
        2'd1:    merge_data[15:8]  = wdata[7:0];
        2'd2:    merge_data[23:16] = wdata[7:0];
        2'd3:    merge_data[31:24] = wdata[7:0];
        default: merge_data[7:0]   = wdata[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      load_data  = {{16{~zero_ext & half_sel[15]}}, half_sel};
      merge_data = lane[1] ? {wdata[15:0], rd_word[15:0]} : {rd_word[31:16], wdata[15:0]};
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store,
// with sub-word stores done as read-modify-write.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pc_enable
);

  state_t            state, state_nxt;
  req_id_t           id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q, we_q, mis_q;
  logic [DATA_W-1:0] wdata_q, rd_word_q, if_instr_q, d_rdata_q;
  logic [DATA_W-1:0] align_word, load_data, merge_data;
  logic              req_mis, in_resp;

  assign req_mis = is_misaligned(d_size, d_addr[1:0]);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_req) begin
          if (req_mis)                       state_nxt = RESP;
          else if (d_we && is_word(d_size))  state_nxt = DSTORE;
          else                               state_nxt = DLOAD;
        end else if (if_req) begin
          state_nxt = FETCH;
        end
      end
      FETCH:           state_nxt = RESP;
      DLOAD:           state_nxt = we_q ? DRMW_WR : RESP;
      DSTORE, DRMW_WR: state_nxt = RESP;
      RESP:            state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q       <= REQ_FETCH;
      addr_q     <= '0;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      mis_q      <= 1'b0;
      wdata_q    <= '0;
      rd_word_q  <= '0;
      if_instr_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req) begin
            id_q    <= REQ_DATA;
            addr_q  <= d_addr;
            size_q  <= d_size;
            uns_q   <= d_unsigned;
            we_q    <= d_we;
            mis_q   <= req_mis;
            wdata_q <= d_wdata;
            if (req_mis) d_rdata_q <= '0;
          end else if (if_req) begin
            id_q    <= REQ_FETCH;
            addr_q  <= if_addr;
            size_q  <= SZ_WORD;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            wdata_q <= '0;
          end
        end
        FETCH: if_instr_q <= mem_rdata;
        DLOAD: begin
          rd_word_q <= mem_rdata;
          if (!we_q) d_rdata_q <= load_data;
        end
        default: ;
      endcase
    end
  end

  // The merge works on the word captured in DLOAD; loads extract straight from memory.
  assign align_word = (state == DRMW_WR) ? rd_word_q : mem_rdata;

  mem_lane_align u_lane_align (
    .rd_word    (align_word),
    .lane       (addr_q[1:0]),
    .size       (size_q),
    .zero_ext   (uns_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Outputs are gated by rst so an aborted transaction can neither write nor respond.
  assign in_resp    = (state == RESP) && !rst;
  assign if_ready   = in_resp && (id_q == REQ_FETCH);
  assign d_ready    = in_resp && (id_q == REQ_DATA);
  assign d_misalign = d_ready && mis_q;
  assign pc_enable  = if_ready;
  assign mem_we     = !rst && ((state == DSTORE) || (state == DRMW_WR));
  assign mem_addr   = rst ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = (state == DRMW_WR) ? merge_data : wdata_q;
  assign if_instr   = if_instr_q;
  assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a word-array reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, d_unsigned;
  logic [11:0] if_addr, d_addr, mem_addr;
  logic [1:0]  d_size;
  logic [31:0] d_wdata, if_instr, d_rdata, mem_wdata, mem_rdata;
  logic        if_ready, d_ready, d_misalign, mem_we, pc_enable;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_instr(if_instr),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .d_misalign(d_misalign), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pc_enable(pc_enable)
  );

  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_mis;
    int          exp_lat;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: access rules expressed as byte counts and offsets on a word array.
  function automatic int nbytes_of(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic ref_mis(input logic [1:0] size, input logic [11:0] addr);
    return (int'(addr) % nbytes_of(size)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns, input logic [11:0] addr);
    int          n    = nbytes_of(size);
    int          off  = (int'(addr) % 4) / n * n;
    logic [31:0] val  = ref_mem[int'(addr) / 4] >> (8 * off);
    logic [31:0] span;
    if (n == 4) return val;
    span = 32'd1 << (8 * n);
    val  = val % span;
    if (!uns && val >= (span / 2)) val = val - span;
    return val;
  endfunction

  function automatic void ref_store(input logic [1:0] size, input logic [11:0] addr, input logic [31:0] wdata);
    int          n   = nbytes_of(size);
    int          off = (int'(addr) % 4) / n * n;
    int          w   = int'(addr) / 4;
    logic [31:0] mask;
    mask = (n == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * n)) - 32'd1) << (8 * off));
    ref_mem[w] = (ref_mem[w] & ~mask) | ((wdata << (8 * off)) & mask);
  endfunction

  task automatic data_txn(input string nm, input logic we, input logic [1:0] size, input logic uns,
                          input logic [11:0] addr, input logic [31:0] wdata, input logic chk_rd,
                          input logic [31:0] exp_rd, input logic exp_mis, input int exp_lat);
    int          lat = -1, we_cnt = 0, we_cyc = -1, pc_cnt = 0;
    int          widx = int'(addr) / 4;
    logic [31:0] act_rd = '0;
    logic        act_mis = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wdata;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(negedge clk);
      if (mem_we) begin we_cnt++; we_cyc = k; end
      if (pc_enable) pc_cnt++;
      if (d_ready) begin
        lat = k; act_rd = d_rdata; act_mis = d_misalign; d_req = 1'b0;
      end
    end
    d_req = 1'b0;
    check({nm, " latency"}, 32'(lat), 32'(exp_lat));
    if (lat >= 0) begin
      check({nm, " misalign"}, {31'd0, act_mis}, {31'd0, exp_mis});
      if (chk_rd) check({nm, " rdata"}, act_rd, exp_rd);
      @(negedge clk);
      check({nm, " ready pulse width"}, {31'd0, d_ready}, 32'd0);
    end
    check({nm, " write count"}, 32'(we_cnt), (we && !exp_mis) ? 32'd1 : 32'd0);
    if (we && !exp_mis) check({nm, " write cycle"}, 32'(we_cyc), 32'(exp_lat - 1));
    check({nm, " pc_enable on data"}, 32'(pc_cnt), 32'd0);
    if (we && !exp_mis) ref_store(size, addr, wdata);
    check({nm, " memory word"}, mem[widx], ref_mem[widx]);
  endtask

  task automatic fetch_txn(input string nm, input logic [11:0] addr);
    int          lat = -1, pc_bad = 0;
    logic [31:0] act = '0;
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(negedge clk);
      if (pc_enable != if_ready || mem_we) pc_bad++;
      if (if_ready) begin lat = k; act = if_instr; if_req = 1'b0; end
    end
    if_req = 1'b0;
    check({nm, " latency"}, 32'(lat), 32'd2);
    check({nm, " instr"}, act, ref_mem[int'(addr) / 4]);
    check({nm, " pc_enable/mem_we"}, 32'(pc_bad), 32'd0);
  endtask

  task automatic random_data(input int i);
    logic [1:0]  size = 2'($urandom_range(0, 3));
    logic        we   = 1'($urandom_range(0, 1));
    logic        uns  = 1'($urandom_range(0, 1));
    logic [11:0] addr = 12'($urandom_range(0, 63));
    logic [31:0] wd   = $urandom;
    logic        mis  = ref_mis(size, addr);
    int          lat  = mis ? 1 : (we && nbytes_of(size) < 4) ? 3 : 2;
    logic [31:0] erd  = mis ? 32'd0 : ref_load(size, uns, addr);
    data_txn($sformatf("rnd%0d", i), we, size, uns, addr, wd, mis || !we, erd, mis, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          lat_d, lat_f, pc_bad, k1, k2;
    logic [31:0] rd_d, ins_f, ins1, ins2;

    for (int i = 0; i < 1024; i++) begin
      mem[i] = (i < 16) ? $urandom : 32'd0;
      ref_mem[i] = mem[i];
    end
    mem[1] = 32'hA5A5_5A5A; ref_mem[1] = 32'hA5A5_5A5A;
    mem[2] = 32'h0102_0304; ref_mem[2] = 32'h0102_0304;
    mem[4] = 32'h8000_00F0; ref_mem[4] = 32'h8000_00F0;

    // Reset with requests pending: nothing may respond or drive memory.
    rst = 1'b1; if_req = 1'b1; if_addr = 12'h7FC; d_req = 1'b1; d_we = 1'b1;
    d_size = 2'b10; d_unsigned = 1'b0; d_addr = 12'h7FC; d_wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    check("reset if_ready", {31'd0, if_ready}, 32'd0);
    check("reset d_ready", {31'd0, d_ready}, 32'd0);
    check("reset mem_we", {31'd0, mem_we}, 32'd0);
    check("reset mem_addr", {20'd0, mem_addr}, 32'd0);
    check("reset pc_enable", {31'd0, pc_enable}, 32'd0);
    check("reset if_instr", if_instr, 32'd0);
    check("reset d_rdata", d_rdata, 32'd0);
    check("reset d_misalign", {31'd0, d_misalign}, 32'd0);
    if_req = 1'b0; d_req = 1'b0; rst = 1'b0;

    //            we    size   uns   addr     wdata          chk   exp_rd         mis  lat
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 12'h010, 32'h0,         1'b1, 32'hFFFF_FFF0, 1'b0, 2};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 12'h010, 32'h0,         1'b1, 32'h0000_00F0, 1'b0, 2};
    vecs[2]  = '{1'b0, 2'b01, 1'b0, 12'h012, 32'h0,         1'b1, 32'hFFFF_8000, 1'b0, 2};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 12'h012, 32'h0,         1'b1, 32'h0000_8000, 1'b0, 2};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 12'h010, 32'h0,         1'b1, 32'h8000_00F0, 1'b0, 2};
    vecs[5]  = '{1'b1, 2'b10, 1'b0, 12'h010, 32'h1122_3344, 1'b0, 32'h0,         1'b0, 2};
    vecs[6]  = '{1'b1, 2'b01, 1'b0, 12'h012, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 3};
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 12'h010, 32'h0,         1'b1, 32'hBEEF_3344, 1'b0, 2};
    vecs[8]  = '{1'b0, 2'b10, 1'b0, 12'h006, 32'h0,         1'b1, 32'h0,         1'b1, 1};
    vecs[9]  = '{1'b1, 2'b00, 1'b0, 12'h013, 32'h1234_5677, 1'b0, 32'h0,         1'b0, 3};
    vecs[10] = '{1'b0, 2'b00, 1'b0, 12'h013, 32'h0,         1'b1, 32'h0000_0077, 1'b0, 2};
    vecs[11] = '{1'b0, 2'b01, 1'b0, 12'h011, 32'h0,         1'b1, 32'h0,         1'b1, 1};
    vecs[12] = '{1'b0, 2'b11, 1'b0, 12'h010, 32'h0,         1'b1, 32'h77EF_3344, 1'b0, 2};
    vecs[13] = '{1'b1, 2'b01, 1'b0, 12'h007, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1, 1};
    vecs[14] = '{1'b0, 2'b01, 1'b0, 12'h006, 32'h0,         1'b1, 32'hFFFF_A5A5, 1'b0, 2};
    vecs[15] = '{1'b0, 2'b00, 1'b1, 12'h005, 32'h0,         1'b1, 32'h0000_005A, 1'b0, 2};
    vecs[16] = '{1'b0, 2'b00, 1'b0, 12'h006, 32'h0,         1'b1, 32'hFFFF_FFA5, 1'b0, 2};

    for (int i = 0; i < 17; i++)
      data_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
               vecs[i].wdata, vecs[i].chk_rd, vecs[i].exp_rd, vecs[i].exp_mis, vecs[i].exp_lat);

    // Simultaneous requests: data first, fetch accepted in the IDLE cycle after data RESP.
    lat_d = -1; lat_f = -1; pc_bad = 0; rd_d = '0; ins_f = '0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_unsigned = 1'b0; d_addr = 12'h004;
    if_req = 1'b1; if_addr = 12'h010;
    for (int k = 1; k <= 12 && lat_f < 0; k++) begin
      @(negedge clk);
      if (pc_enable != if_ready) pc_bad++;
      if (d_ready) begin lat_d = k; rd_d = d_rdata; d_req = 1'b0; end
      if (if_ready) begin lat_f = k; ins_f = if_instr; if_req = 1'b0; end
    end
    d_req = 1'b0; if_req = 1'b0;
    check("arb data latency", 32'(lat_d), 32'd2);
    check("arb fetch latency", 32'(lat_f), 32'd5);
    check("arb data rdata", rd_d, ref_mem[1]);
    check("arb fetch instr", ins_f, ref_mem[4]);
    check("arb pc_enable", 32'(pc_bad), 32'd0);

    // Back-to-back fetches with if_req held; address moves on after the first ready.
    k1 = -1; k2 = -1; ins1 = '0; ins2 = '0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 12'h000;
    for (int k = 1; k <= 12 && k2 < 0; k++) begin
      @(negedge clk);
      if (if_ready) begin
        if (k1 < 0) begin k1 = k; ins1 = if_instr; if_addr = 12'h004; end
        else begin k2 = k; ins2 = if_instr; if_req = 1'b0; end
      end
    end
    if_req = 1'b0;
    check("b2b first ready", 32'(k1), 32'd2);
    check("b2b second ready", 32'(k2), 32'd5);
    check("b2b first instr", ins1, ref_mem[0]);
    check("b2b second instr", ins2, ref_mem[1]);

    // Reset while the RMW write is being presented: the write and the response are lost.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_unsigned = 1'b0; d_addr = 12'h008; d_wdata = 32'h0000_00AB;
    @(negedge clk);
    check("rmw abort read phase mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    check("rmw abort write phase mem_we", {31'd0, mem_we}, 32'd1);
    rst = 1'b1; d_req = 1'b0;
    #1;
    check("rmw abort gated mem_we", {31'd0, mem_we}, 32'd0);
    check("rmw abort mem_addr", {20'd0, mem_addr}, 32'd0);
    @(negedge clk);
    check("post abort d_ready", {31'd0, d_ready}, 32'd0);
    check("post abort mem_we", {31'd0, mem_we}, 32'd0);
    check("post abort if_instr", if_instr, 32'd0);
    check("post abort d_rdata", d_rdata, 32'd0);
    check("post abort mem_addr", {20'd0, mem_addr}, 32'd0);
    rst = 1'b0;
    check("post abort memory", mem[2], 32'h0102_0304);
    data_txn("rmw reissue", 1'b1, 2'b00, 1'b0, 12'h008, 32'h0000_00AB, 1'b0, 32'h0, 1'b0, 3);
    check("rmw reissue value", mem[2], 32'h0102_03AB);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) fetch_txn($sformatf("rndf%0d", i), 12'($urandom_range(0, 15) * 4));
      else random_data(i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have fetch ports: if_req  in  1  fetch request (held until if_ready); if_addr  in  12  byte address; if_ready  out  1  one-cycle done pulse; if_instr  out  32  fetched word, valid with if_ready.
REQ-003 SHALL have data ports: d_req  in  1; d_we  in  1  store=1/load=0; d_size  in  2  00 byte/01 half/10 word (11 treated as word); d_unsigned  in  1  zero-extend loads; d_addr  in  12; d_wdata  in  32  store data in low bits; d_ready  out  1  pulse; d_rdata  out  32  extended load data; d_misalign  out  1  error, valid with d_ready.
REQ-004 SHALL have memory ports: mem_addr  out  12  byte address, bits[1:0]=00; mem_we  out  1; mem_wdata  out  32; mem_rdata  in  32  combinational read of mem_addr; pc_enable  out  1  PC advance strobe.
REQ-005 Parameter: none; address width fixed at 12, data width 32.

Function
REQ-006 SHALL implement FSM states IDLE, FETCH, DLOAD, DSTORE, DRMW_WR, RESP.
REQ-007 Requests SHALL be sampled only in IDLE; d_req wins over if_req when both high.
REQ-008 On acceptance, SHALL register address, size, unsigned, we, wdata, and requester id.
REQ-009 IDLE->FETCH on if_req; IDLE->DLOAD on load or sub-word store; IDLE->DSTORE on aligned word store; IDLE->RESP on misaligned data request.
REQ-010 Misaligned: half with addr[0]=1, word with addr[1:0]!=00; SHALL not access memory, SHALL assert d_misalign with d_ready, d_rdata=0.
REQ-011 FETCH and DLOAD SHALL drive mem_addr={addr[11:2],2'b00}, mem_we=0, and register mem_rdata at end of cycle.
REQ-012 FETCH->RESP; DLOAD->RESP for loads, DLOAD->DRMW_WR for sub-word stores.
REQ-013 DRMW_WR SHALL write the read word with only the addressed byte (addr[1:0]) or half (addr[1]) lanes replaced by d_wdata low bits; DSTORE SHALL write d_wdata whole; both assert mem_we for exactly one cycle, then go RESP.
REQ-014 Load extension: byte/half SHALL be extracted from the addressed lane, sign-extended unless d_unsigned; word passed through.
REQ-015 RESP SHALL pulse if_ready or d_ready (matching requester) for one cycle, then return to IDLE; no request accepted in RESP.
REQ-016 pc_enable SHALL equal 1 only in the RESP cycle of a fetch.
REQ-017 Latency from accepting cycle N: fetch/load/word store ready at N+2; sub-word store ready at N+3; misaligned ready at N+1.
REQ-018 if_instr and d_rdata SHALL hold their last values until the next completion of the same kind.
REQ-019 mem_we SHALL be 0 in every state other than DSTORE/DRMW_WR and whenever rst=1.

Reset
REQ-020 rst sampled high SHALL force IDLE and clear if_ready, d_ready, d_misalign, pc_enable, if_instr, d_rdata, all captured registers.
REQ-021 rst mid-operation SHALL abort the transaction with no write and no ready pulse; requester re-issues.
REQ-022 mem_addr SHALL be 0 during reset.

Structure
REQ-023 Package mem_arb_pkg SHALL hold the state enum, the d_size encoding constants, and address/data width constants.
REQ-024 Byte-lane extract/extend and lane-merge logic SHALL live in combinational sub-module mem_lane_align.

Verification
REQ-025 Word at 0x010 = 0x8000_00F0, load byte addr 0x010 signed -> d_rdata=0xFFFF_FFF0 at N+2; unsigned -> 0x0000_00F0.
REQ-026 SH 0xBEEF to 0x012 over 0x1122_3344 -> one mem_we pulse at N+2, memory=0xBEEF_3344, d_ready at N+3.
REQ-027 if_req and d_req same IDLE cycle -> data served first; fetch accepted cycle after data RESP; pc_enable only with if_ready.
REQ-028 LW at 0x006 -> d_ready+d_misalign at N+1, mem_we never asserted, memory unchanged.
REQ-029 rst asserted during DRMW_WR -> no write, FSM IDLE next cycle, all outputs at reset values.
REQ-030 Back-to-back fetches at 0x000,0x004 held continuously -> if_ready at N+2 and N+5, correct words.
